// File: rtl/data_memory_stack_pkg.sv
// Shared encodings for the data memory / hardware stack block.
package data_memory_stack_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_PUSH  = 2'b10,
    OP_POP   = 2'b11
  } op_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/data_memory_stack_ram.sv
// DEPTH x DATA_W storage: one write port, one registered read port.
module dm_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array has no reset so it can map onto a RAM macro; zeroing is done by CLEAR.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register holds its value when no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_stack.sv
// Data memory with hardware stack pointer, bounds flags and post-reset zero fill.
module data_memory_stack
  import data_memory_stack_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int STACK_BASE     = (1 << ADDR_W) - 1,
  parameter int STACK_LIMIT    = (1 << ADDR_W) - 64,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              data_sel,
  input  logic [DATA_W-1:0] rn_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic              sp_load,
  input  logic [ADDR_W-1:0] sp_load_val,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] sp_out,
  output logic              ovf,
  output logic              unf,
  input  logic              err_clr,
  output logic              busy
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] L_BASE  = ADDR_W'(STACK_BASE);
  localparam logic [ADDR_W-1:0] L_LIMIT = ADDR_W'(STACK_LIMIT);
  localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(DEPTH - 1);
  localparam state_e            L_RST_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_e            r_state, w_next_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] r_sp;
  logic              r_ovf, r_unf, r_rd_valid;

  logic              w_clearing, w_accept;
  logic              w_is_read, w_is_write, w_is_push, w_is_pop;
  logic              w_push_ok, w_push_ovf, w_pop_ok, w_pop_unf;
  logic [ADDR_W-1:0] w_sp_dec, w_sp_inc;
  logic [DATA_W-1:0] w_op_wdata;
  logic              w_ram_we, w_ram_re;
  logic [ADDR_W-1:0] w_ram_waddr, w_ram_raddr;
  logic [DATA_W-1:0] w_ram_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= L_RST_ST;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_clearing   = 1'b0;
    op_ready     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clearing = 1'b1;
        if (r_clr_cnt == L_LAST) w_next_state = ST_IDLE;
      end
      ST_IDLE: begin
        op_ready = ~sp_load;
      end
      default: w_next_state = L_RST_ST;
    endcase
  end

  assign busy = w_clearing;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_clr_cnt <= '0;
    else if (w_clearing) r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
  end

  assign w_accept   = op_valid & op_ready;
  assign w_is_read  = w_accept & (op_e'(op) == OP_READ);
  assign w_is_write = w_accept & (op_e'(op) == OP_WRITE);
  assign w_is_push  = w_accept & (op_e'(op) == OP_PUSH);
  assign w_is_pop   = w_accept & (op_e'(op) == OP_POP);

  // Bounds are equality checks only; an SP loaded outside the window is not trapped.
  assign w_push_ok  = w_is_push & (r_sp != L_LIMIT);
  assign w_push_ovf = w_is_push & (r_sp == L_LIMIT);
  assign w_pop_ok   = w_is_pop  & (r_sp != L_BASE);
  assign w_pop_unf  = w_is_pop  & (r_sp == L_BASE);

  assign w_sp_dec   = r_sp - ADDR_W'(1);
  assign w_sp_inc   = r_sp + ADDR_W'(1);
  assign w_op_wdata = data_sel ? rn_in : npc_in;

  assign w_ram_we    = w_clearing | w_is_write | w_push_ok;
  assign w_ram_waddr = w_clearing ? r_clr_cnt : (w_push_ok ? w_sp_dec : addr_in);
  assign w_ram_wdata = w_clearing ? '0 : w_op_wdata;
  assign w_ram_re    = w_is_read | w_pop_ok;
  assign w_ram_raddr = w_pop_ok ? r_sp : addr_in;

  dm_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_sp <= L_BASE;
    else if (sp_load && r_state == ST_IDLE) r_sp <= sp_load_val;
    else if (w_push_ok)                     r_sp <= w_sp_dec;
    else if (w_pop_ok)                      r_sp <= w_sp_inc;
  end

  // A fault in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_ram_re;
      if (w_push_ovf)   r_ovf <= 1'b1;
      else if (err_clr) r_ovf <= 1'b0;
      if (w_pop_unf)    r_unf <= 1'b1;
      else if (err_clr) r_unf <= 1'b0;
    end
  end

  assign sp_out   = r_sp;
  assign ovf      = r_ovf;
  assign unf      = r_unf;
  assign rd_valid = r_rd_valid;

endmodule
